// File: rtl/commit_unit.sv
// commit_unit: in-order commit stage behind the reorder buffer.
// Writes the architectural register file and releases rename tags.
// Hands stores to the data-memory port through a valid/ready handshake.
// Flushes the pipeline and redirects fetch on a mispredicted branch.
//
// state        | meaning
// -------------+------------------------------------------------------
// S_IDLE       | ready to accept one retire entry per cycle
// S_STORE_WAIT | store request outstanding, waiting for Store_commit_ready
// S_FLUSH      | Flush asserted, down-counter running to zero
module commit_unit #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Retire_valid,
  input  logic [4:0]  Retire_rd_tag,
  input  logic [4:0]  Retire_rd_reg,
  input  logic [31:0] Retire_data,
  input  logic [31:0] Retire_pc,
  input  logic        Retire_branch,
  input  logic        Retire_branch_taken,
  input  logic        Retire_store_ready,
  output logic        Commit_stall,
  input  logic [4:0]  Arf_rd_addr1,
  input  logic [4:0]  Arf_rd_addr2,
  output logic [31:0] Arf_rd_data1,
  output logic [31:0] Arf_rd_data2,
  output logic [4:0]  Rst_clear_tag,
  output logic        Rst_clear_valid,
  output logic        Store_commit_valid,
  output logic [4:0]  Store_commit_tag,
  input  logic        Store_commit_ready,
  output logic        Flush,
  output logic        Redirect_valid,
  output logic [31:0] Redirect_pc,
  output logic [31:0] Commit_count
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_STORE_WAIT = 2'd1,
    S_FLUSH      = 2'd2
  } state_t;

  // Counter holds remaining flush cycles minus one, so it starts at N-1.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  flush_cnt;
  logic [31:0] arf [32];

  logic accept;
  logic take_mispredict;
  logic take_store;
  logic take_regwrite;
  logic arf_we;

  // Classify the presented entry; branch wins over store, store over register write.
  always_comb begin
    accept          = (state == S_IDLE) && Retire_valid;
    take_mispredict = accept && Retire_branch && Retire_branch_taken;
    take_store      = accept && !Retire_branch && Retire_store_ready;
    take_regwrite   = accept && !Retire_branch && !Retire_store_ready;
    arf_we          = take_regwrite && (Retire_rd_reg != 5'd0);
    Commit_stall    = (state != S_IDLE);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (take_mispredict) begin
          state_next = S_FLUSH;
        end else if (take_store) begin
          state_next = S_STORE_WAIT;
        end
      end
      S_STORE_WAIT: begin
        if (Store_commit_ready) begin
          state_next = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (flush_cnt == 4'd0) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register and flush down-counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      flush_cnt <= 4'd0;
    end else begin
      state <= state_next;
      if (take_mispredict) begin
        flush_cnt <= FLUSH_LOAD;
      end else if ((state == S_FLUSH) && (flush_cnt != 4'd0)) begin
        flush_cnt <= flush_cnt - 4'd1;
      end
    end
  end

  // Registered outputs toward the rename table, store port, fetch and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Rst_clear_valid    <= 1'b0;
      Rst_clear_tag      <= 5'd0;
      Store_commit_valid <= 1'b0;
      Store_commit_tag   <= 5'd0;
      Flush              <= 1'b0;
      Redirect_valid     <= 1'b0;
      Redirect_pc        <= 32'd0;
      Commit_count       <= 32'd0;
    end else begin
      Rst_clear_valid    <= take_regwrite;
      Store_commit_valid <= (state_next == S_STORE_WAIT);
      Flush              <= (state_next == S_FLUSH);
      Redirect_valid     <= take_mispredict;
      if (take_regwrite) begin
        Rst_clear_tag <= Retire_rd_tag;
      end
      if (take_store) begin
        Store_commit_tag <= Retire_rd_tag;
      end
      if (take_mispredict) begin
        Redirect_pc <= Retire_pc;
      end
      if (accept) begin
        Commit_count <= Commit_count + 32'd1;
      end
    end
  end

  // Architectural register file; register 0 is never written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        arf[i] <= 32'd0;
      end
    end else if (arf_we) begin
      arf[Retire_rd_reg] <= Retire_data;
    end
  end

  // Combinational read ports with same-cycle write bypass; address 0 reads zero.
  always_comb begin
    Arf_rd_data1 = 32'd0;
    Arf_rd_data2 = 32'd0;
    if (Arf_rd_addr1 != 5'd0) begin
      if (arf_we && (Arf_rd_addr1 == Retire_rd_reg)) begin
        Arf_rd_data1 = Retire_data;
      end else begin
        Arf_rd_data1 = arf[Arf_rd_addr1];
      end
    end
    if (Arf_rd_addr2 != 5'd0) begin
      if (arf_we && (Arf_rd_addr2 == Retire_rd_reg)) begin
        Arf_rd_data2 = Retire_data;
      end else begin
        Arf_rd_data2 = arf[Arf_rd_addr2];
      end
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Testbench for commit_unit: directed steps followed by a randomized sequence,
// checked against a transaction-level model (register array + commit counter).
module tb_commit_unit;

  localparam int FC = 2;

  logic        clock;
  logic        reset;
  logic        Retire_valid;
  logic [4:0]  Retire_rd_tag;
  logic [4:0]  Retire_rd_reg;
  logic [31:0] Retire_data;
  logic [31:0] Retire_pc;
  logic        Retire_branch;
  logic        Retire_branch_taken;
  logic        Retire_store_ready;
  logic        Commit_stall;
  logic [4:0]  Arf_rd_addr1;
  logic [4:0]  Arf_rd_addr2;
  logic [31:0] Arf_rd_data1;
  logic [31:0] Arf_rd_data2;
  logic [4:0]  Rst_clear_tag;
  logic        Rst_clear_valid;
  logic        Store_commit_valid;
  logic [4:0]  Store_commit_tag;
  logic        Store_commit_ready;
  logic        Flush;
  logic        Redirect_valid;
  logic [31:0] Redirect_pc;
  logic [31:0] Commit_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_arf [32];
  logic [31:0] m_count;

  commit_unit #(.FLUSH_CYCLES(FC)) dut (
    .clock               (clock),
    .reset               (reset),
    .Retire_valid        (Retire_valid),
    .Retire_rd_tag       (Retire_rd_tag),
    .Retire_rd_reg       (Retire_rd_reg),
    .Retire_data         (Retire_data),
    .Retire_pc           (Retire_pc),
    .Retire_branch       (Retire_branch),
    .Retire_branch_taken (Retire_branch_taken),
    .Retire_store_ready  (Retire_store_ready),
    .Commit_stall        (Commit_stall),
    .Arf_rd_addr1        (Arf_rd_addr1),
    .Arf_rd_addr2        (Arf_rd_addr2),
    .Arf_rd_data1        (Arf_rd_data1),
    .Arf_rd_data2        (Arf_rd_data2),
    .Rst_clear_tag       (Rst_clear_tag),
    .Rst_clear_valid     (Rst_clear_valid),
    .Store_commit_valid  (Store_commit_valid),
    .Store_commit_tag    (Store_commit_tag),
    .Store_commit_ready  (Store_commit_ready),
    .Flush               (Flush),
    .Redirect_valid      (Redirect_valid),
    .Redirect_pc         (Redirect_pc),
    .Commit_count        (Commit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_arf[i] = 32'd0;
    m_count = 32'd0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_stall", Commit_stall, 0);
    chk("rst_clear_valid", Rst_clear_valid, 0);
    chk("rst_clear_tag", Rst_clear_tag, 0);
    chk("rst_store_valid", Store_commit_valid, 0);
    chk("rst_store_tag", Store_commit_tag, 0);
    chk("rst_flush", Flush, 0);
    chk("rst_redirect_valid", Redirect_valid, 0);
    chk("rst_redirect_pc", Redirect_pc, 0);
    chk("rst_count", Commit_count, 0);
    chk("rst_rd1", Arf_rd_data1, 0);
    chk("rst_rd2", Arf_rd_data2, 0);
  endtask

  // Register-writing retire, including bypass check before the edge and
  // one-cycle release pulse after it. Called just after a falling edge.
  task automatic do_regwrite(input logic [4:0] tag, input logic [4:0] rreg, input logic [31:0] data);
    logic [31:0] e1;
    logic [31:0] e2;
    Retire_valid        = 1'b1;
    Retire_branch       = 1'b0;
    Retire_branch_taken = 1'b0;
    Retire_store_ready  = 1'b0;
    Retire_rd_tag       = tag;
    Retire_rd_reg       = rreg;
    Retire_data         = data;
    Arf_rd_addr1        = rreg;
    Arf_rd_addr2        = 5'($urandom_range(0, 31));
    #1;
    e1 = (rreg == 5'd0) ? 32'd0 : data;
    if (Arf_rd_addr2 == 5'd0) e2 = 32'd0;
    else if (Arf_rd_addr2 == rreg) e2 = data;
    else e2 = m_arf[Arf_rd_addr2];
    chk("wr_bypass1", Arf_rd_data1, e1);
    chk("wr_bypass2", Arf_rd_data2, e2);
    @(posedge clock);
    if (rreg != 5'd0) m_arf[rreg] = data;
    m_count = m_count + 32'd1;
    @(negedge clock);
    Retire_valid = 1'b0;
    #1;
    chk("wr_arf", Arf_rd_data1, m_arf[rreg]);
    chk("wr_clear_valid", Rst_clear_valid, 1);
    chk("wr_clear_tag", Rst_clear_tag, tag);
    chk("wr_count", Commit_count, m_count);
    chk("wr_stall", Commit_stall, 0);
    @(negedge clock);
    #1;
    chk("wr_clear_drop", Rst_clear_valid, 0);
  endtask

  // Correctly predicted branch, optionally also flagged as a store.
  task automatic do_good_branch(input logic sflag);
    Retire_valid        = 1'b1;
    Retire_branch       = 1'b1;
    Retire_branch_taken = 1'b0;
    Retire_store_ready  = sflag;
    Retire_rd_tag       = 5'($urandom);
    Retire_rd_reg       = 5'($urandom);
    Retire_data         = $urandom;
    Retire_pc           = $urandom;
    Arf_rd_addr1        = Retire_rd_reg;
    #1;
    chk("br_no_bypass", Arf_rd_data1, m_arf[Retire_rd_reg]);
    @(posedge clock);
    m_count = m_count + 32'd1;
    @(negedge clock);
    Retire_valid = 1'b0;
    #1;
    chk("br_flush", Flush, 0);
    chk("br_redirect", Redirect_valid, 0);
    chk("br_store_valid", Store_commit_valid, 0);
    chk("br_clear_valid", Rst_clear_valid, 0);
    chk("br_stall", Commit_stall, 0);
    chk("br_count", Commit_count, m_count);
    chk("br_no_write", Arf_rd_data1, m_arf[Retire_rd_reg]);
  endtask

  // Mispredicted branch; a register-writing entry is held valid during the
  // flush and must only be taken once the stall drops.
  task automatic do_mispredict(input logic [31:0] pc, input logic [4:0] htag,
                               input logic [4:0] hreg, input logic [31:0] hdata);
    Retire_valid        = 1'b1;
    Retire_branch       = 1'b1;
    Retire_branch_taken = 1'b1;
    Retire_store_ready  = 1'($urandom_range(0, 1));
    Retire_pc           = pc;
    Retire_rd_tag       = 5'($urandom);
    Retire_rd_reg       = hreg;
    Retire_data         = $urandom;
    @(posedge clock);
    m_count = m_count + 32'd1;
    @(negedge clock);
    Retire_branch       = 1'b0;
    Retire_branch_taken = 1'b0;
    Retire_store_ready  = 1'b0;
    Retire_rd_tag       = htag;
    Retire_rd_reg       = hreg;
    Retire_data         = hdata;
    Arf_rd_addr1        = hreg;
    #1;
    chk("mp_flush_first", Flush, 1);
    chk("mp_redirect_first", Redirect_valid, 1);
    chk("mp_redirect_pc", Redirect_pc, pc);
    chk("mp_stall_first", Commit_stall, 1);
    chk("mp_store_valid", Store_commit_valid, 0);
    chk("mp_count", Commit_count, m_count);
    chk("mp_held_no_bypass", Arf_rd_data1, m_arf[hreg]);
    for (int k = 1; k < FC; k++) begin
      @(negedge clock);
      #1;
      chk("mp_flush_hold", Flush, 1);
      chk("mp_redirect_drop", Redirect_valid, 0);
      chk("mp_stall_hold", Commit_stall, 1);
      chk("mp_held_not_taken", Commit_count, m_count);
    end
    @(negedge clock);
    #1;
    chk("mp_flush_end", Flush, 0);
    chk("mp_stall_end", Commit_stall, 0);
    chk("mp_redirect_end", Redirect_valid, 0);
    chk("mp_count_end", Commit_count, m_count);
    do_regwrite(htag, hreg, hdata);
  endtask

  // Store with `delay` edges of ready low before ready is seen high.
  // Ready is high at the accepting edge, where it must be ignored.
  task automatic do_store(input logic [4:0] tag, input int delay);
    Retire_valid        = 1'b1;
    Retire_branch       = 1'b0;
    Retire_branch_taken = 1'b0;
    Retire_store_ready  = 1'b1;
    Retire_rd_tag       = tag;
    Retire_rd_reg       = 5'($urandom);
    Retire_data         = $urandom;
    Arf_rd_addr1        = Retire_rd_reg;
    Store_commit_ready  = 1'b1;
    #1;
    chk("st_no_bypass", Arf_rd_data1, m_arf[Retire_rd_reg]);
    @(posedge clock);
    m_count = m_count + 32'd1;
    @(negedge clock);
    Retire_valid       = 1'b0;
    Store_commit_ready = 1'b0;
    #1;
    chk("st_valid_first", Store_commit_valid, 1);
    chk("st_tag", Store_commit_tag, tag);
    chk("st_stall", Commit_stall, 1);
    chk("st_count", Commit_count, m_count);
    chk("st_clear_valid", Rst_clear_valid, 0);
    repeat (delay) begin
      @(negedge clock);
      #1;
      chk("st_valid_hold", Store_commit_valid, 1);
      chk("st_tag_hold", Store_commit_tag, tag);
      chk("st_stall_hold", Commit_stall, 1);
    end
    Store_commit_ready = 1'b1;
    @(negedge clock);
    Store_commit_ready = 1'b0;
    #1;
    chk("st_valid_drop", Store_commit_valid, 0);
    chk("st_stall_drop", Commit_stall, 0);
    chk("st_count_once", Commit_count, m_count);
    chk("st_no_write", Arf_rd_data1, m_arf[Retire_rd_reg]);
  endtask

  initial begin
    int kind;
    reset               = 1'b1;
    Retire_valid        = 1'b0;
    Retire_rd_tag       = 5'd0;
    Retire_rd_reg       = 5'd0;
    Retire_data         = 32'd0;
    Retire_pc           = 32'd0;
    Retire_branch       = 1'b0;
    Retire_branch_taken = 1'b0;
    Retire_store_ready  = 1'b0;
    Store_commit_ready  = 1'b0;
    Arf_rd_addr1        = 5'd5;
    Arf_rd_addr2        = 5'd9;
    model_reset();

    @(negedge clock);
    @(negedge clock);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    // Register write and register-0 write.
    do_regwrite(5'd3, 5'd5, 32'hDEADBEEF);
    do_regwrite(5'd4, 5'd0, 32'h00001234);

    // Mispredict with a held entry during flush.
    do_mispredict(32'h00400080, 5'd11, 5'd12, 32'hCAFEF00D);

    // Store held for three cycles of ready low.
    do_store(5'd7, 3);

    // Branch flagged also as a store is handled as a branch.
    do_good_branch(1'b1);

    // Back-to-back register writes.
    Retire_valid = 1'b1; Retire_branch = 1'b0; Retire_branch_taken = 1'b0;
    Retire_store_ready = 1'b0;
    Retire_rd_tag = 5'd20; Retire_rd_reg = 5'd17; Retire_data = 32'h11112222;
    @(posedge clock);
    m_arf[17] = 32'h11112222; m_count = m_count + 32'd1;
    @(negedge clock);
    chk("b2b_clear_a", Rst_clear_valid, 1);
    chk("b2b_tag_a", Rst_clear_tag, 20);
    Retire_rd_tag = 5'd21; Retire_rd_reg = 5'd18; Retire_data = 32'h33334444;
    @(posedge clock);
    m_arf[18] = 32'h33334444; m_count = m_count + 32'd1;
    @(negedge clock);
    Retire_valid = 1'b0;
    Arf_rd_addr1 = 5'd17; Arf_rd_addr2 = 5'd18;
    #1;
    chk("b2b_clear_b", Rst_clear_valid, 1);
    chk("b2b_tag_b", Rst_clear_tag, 21);
    chk("b2b_arf_a", Arf_rd_data1, m_arf[17]);
    chk("b2b_arf_b", Arf_rd_data2, m_arf[18]);
    chk("b2b_count", Commit_count, m_count);

    // Reset during a pending store.
    @(negedge clock);
    Retire_valid = 1'b1; Retire_store_ready = 1'b1; Retire_rd_tag = 5'd9;
    @(posedge clock);
    @(negedge clock);
    Retire_valid = 1'b0; Retire_store_ready = 1'b0;
    chk("rs_store_pending", Store_commit_valid, 1);
    Arf_rd_addr1 = 5'd5; Arf_rd_addr2 = 5'd17;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_outputs();
    @(negedge clock);
    reset = 1'b0;
    do_regwrite(5'd1, 5'd6, 32'h0BADC0DE);

    // Reset during a flush.
    Retire_valid = 1'b1; Retire_branch = 1'b1; Retire_branch_taken = 1'b1;
    Retire_pc = 32'h00001000;
    @(posedge clock);
    @(negedge clock);
    Retire_valid = 1'b0; Retire_branch = 1'b0; Retire_branch_taken = 1'b0;
    chk("rf_flush_active", Flush, 1);
    Arf_rd_addr1 = 5'd6; Arf_rd_addr2 = 5'd6;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_outputs();
    @(negedge clock);
    reset = 1'b0;
    do_regwrite(5'd2, 5'd6, 32'h5A5A5A5A);

    // Randomized sequence against the model.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1: do_regwrite(5'($urandom), 5'($urandom), $urandom);
        2:    do_good_branch(1'($urandom_range(0, 1)));
        3:    do_mispredict($urandom, 5'($urandom), 5'($urandom), $urandom);
        default: do_store(5'($urandom), $urandom_range(0, 4));
      endcase
    end

    // Final sweep of the register file.
    for (int r = 0; r < 32; r++) begin
      Arf_rd_addr1 = 5'(r);
      Arf_rd_addr2 = 5'(31 - r);
      #1;
      chk("sweep_rd1", Arf_rd_data1, m_arf[r]);
      chk("sweep_rd2", Arf_rd_data2, m_arf[31 - r]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
